// File: rtl/seg_digit_encoder.sv
// seg_digit_encoder
// Converts a binary level (0-15) and a binary two-digit value (0-127, clamped
// to 99) into three active-low seven-segment patterns for the scan driver.
// The binary-to-BCD step uses a shift-add-3 (double-dabble) converter that
// runs over several cycles. All three patterns are registered in the same
// cycle, so the display never shows a half-updated value.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   load       in   one-cycle request to convert level/value (ignored while busy)
//   level      in   [3:0] level number
//   value      in   [6:0] two-digit value, values above 99 clamp to 99
//   busy       out  high while a conversion is in progress
//   done       out  one-cycle pulse when new patterns first appear
//   digitLEVEL out  [6:0] level digit pattern (g..a, active-low)
//   digitLEFT  out  [6:0] tens digit pattern
//   digitRIGHT out  [6:0] ones digit pattern
module seg_digit_encoder #(
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] level,
  input  logic [6:0] value,
  output logic       busy,
  output logic       done,
  output logic [6:0] digitLEVEL,
  output logic [6:0] digitLEFT,
  output logic [6:0] digitRIGHT
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t      state, next_state;
  logic [14:0] shift_reg;   // [14:11] tens, [10:7] ones, [6:0] binary
  logic [14:0] adjusted;
  logic [2:0]  count;
  logic [3:0]  level_reg;

  logic        busy_next, done_next;
  logic [6:0]  level_next, left_next, right_next;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = SEG_DASH;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load) next_state = CONVERT;
      CONVERT: if (count == 3'd6) next_state = UPDATE;
      UPDATE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Add-3 correction applied to each BCD nibble ahead of the shift
  always_comb begin
    adjusted = shift_reg;
    if (shift_reg[14:11] >= 4'd5) adjusted[14:11] = shift_reg[14:11] + 4'd3;
    if (shift_reg[10:7]  >= 4'd5) adjusted[10:7]  = shift_reg[10:7]  + 4'd3;
  end

  // Conversion datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      count     <= '0;
      level_reg <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          level_reg <= level;
          shift_reg <= {8'd0, (value > 7'd99) ? 7'd99 : value};
          count     <= '0;
        end
        CONVERT: begin
          shift_reg <= {adjusted[13:0], 1'b0};
          count     <= count + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Output logic: computes next output values, which are then registered so
  // no input reaches an output combinationally.
  always_comb begin
    busy_next  = (next_state != IDLE);
    done_next  = (state == UPDATE);
    level_next = digitLEVEL;
    left_next  = digitLEFT;
    right_next = digitRIGHT;
    if (state == UPDATE) begin
      level_next = glyph(level_reg);
      left_next  = (BLANK_LEADING_ZERO && shift_reg[14:11] == 4'd0)
                   ? SEG_BLANK : glyph(shift_reg[14:11]);
      right_next = glyph(shift_reg[10:7]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      digitLEVEL <= SEG_BLANK;
      digitLEFT  <= SEG_BLANK;
      digitRIGHT <= SEG_BLANK;
    end else begin
      busy       <= busy_next;
      done       <= done_next;
      digitLEVEL <= level_next;
      digitLEFT  <= left_next;
      digitRIGHT <= right_next;
    end
  end

endmodule

// File: tb/tb_seg_digit_encoder.sv
module tb_seg_digit_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] level;
  logic [6:0] value;

  logic       busy0, done0, busy1, done1;
  logic [6:0] lv0, lf0, rt0, lv1, lf1, rt1;

  always #5 clk = ~clk;

  seg_digit_encoder #(.BLANK_LEADING_ZERO(1'b1)) dut0 (
    .clk(clk), .reset(reset), .load(load), .level(level), .value(value),
    .busy(busy0), .done(done0),
    .digitLEVEL(lv0), .digitLEFT(lf0), .digitRIGHT(rt0)
  );

  seg_digit_encoder #(.BLANK_LEADING_ZERO(1'b0)) dut1 (
    .clk(clk), .reset(reset), .load(load), .level(level), .value(value),
    .busy(busy1), .done(done1),
    .digitLEVEL(lv1), .digitLEFT(lf1), .digitRIGHT(rt1)
  );

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;
  logic [6:0] glyphs [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

  typedef struct {
    logic [6:0]  lv;
    logic [6:0]  lf;
    logic [6:0]  rt;
    int unsigned due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned dones0 = 0;
  int unsigned loads_expected = 0;
  logic        prev0 = 1'b0, prev1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int lv, input int v, input bit blz, input int unsigned due);
    exp_t e;
    int   c, t, o;
    c = (v > 99) ? 99 : v;
    t = c / 10;
    o = c % 10;
    e.lv  = (lv > 9) ? DASH : glyphs[lv];
    e.lf  = (blz && t == 0) ? BLANK : glyphs[t];
    e.rt  = glyphs[o];
    e.due = due;
    return e;
  endfunction

  // Scoreboard: compare each done pulse against the oldest expected result
  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      dones0++;
      check("done0_width", {31'd0, prev0}, 32'd0);
      if (q0.size() == 0) check("done0_spurious", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check("lvl0", {25'd0, lv0}, {25'd0, e.lv});
        check("left0", {25'd0, lf0}, {25'd0, e.lf});
        check("right0", {25'd0, rt0}, {25'd0, e.rt});
        check("latency0", cyc, e.due);
        check("busy0_at_done", {31'd0, busy0}, 32'd0);
      end
    end
    if (done1) begin
      check("done1_width", {31'd0, prev1}, 32'd0);
      if (q1.size() == 0) check("done1_spurious", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("lvl1", {25'd0, lv1}, {25'd0, e.lv});
        check("left1", {25'd0, lf1}, {25'd0, e.lf});
        check("right1", {25'd0, rt1}, {25'd0, e.rt});
        check("latency1", cyc, e.due);
      end
    end
    prev0 = done0;
    prev1 = done1;
  end

  task automatic do_load(input int lv, input int v);
    @(negedge clk);
    level = lv[3:0];
    value = v[6:0];
    load  = 1'b1;
    q0.push_back(model(lv, v, 1'b1, cyc + 9));
    q1.push_back(model(lv, v, 1'b0, cyc + 9));
    loads_expected++;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("timeout", 32'd1, 32'd0);
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_lvl"}, {25'd0, lv0}, {25'd0, BLANK});
    check({tag, "_left"}, {25'd0, lf0}, {25'd0, BLANK});
    check({tag, "_right"}, {25'd0, rt0}, {25'd0, BLANK});
    check({tag, "_busy"}, {31'd0, busy0}, 32'd0);
    check({tag, "_done"}, {31'd0, done0}, 32'd0);
  endtask

  int stim_lv [8] = '{3, 12, 5, 9, 0, 1, 15, 10};
  int stim_v  [8] = '{42, 7, 0, 120, 99, 100, 55, 127};

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    level = '0;
    value = '0;
    repeat (2) @(negedge clk);
    check_blank("reset");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_load(stim_lv[i], stim_v[i]);
      wait_idle();
    end

    // A second load while busy must be dropped
    do_load(7, 42);
    repeat (2) @(negedge clk);
    level = 4'd2;
    value = 7'd15;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("busy_after_drop", {31'd0, busy0}, 32'd1);
    wait_idle();
    repeat (12) @(negedge clk);
    check("no_extra_done", dones0, loads_expected);

    // Reset mid-conversion aborts it with no done pulse
    @(negedge clk);
    level = 4'd4;
    value = 7'd88;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_blank("abort");
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done", dones0, loads_expected);
    check_blank("abort_idle");

    do_load(6, 56);
    wait_idle();
    repeat (3) @(negedge clk);
    check("q0_empty", q0.size(), 32'd0);
    check("q1_empty", q1.size(), 32'd0);
    check("done_count", dones0, loads_expected);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
